// File: rtl/hash_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hash_req_arbiter                                                |
// | Purpose  : Shares one hash core among NUM_REQ message sources. A requester |
// |            is picked round-robin, its grant is locked for the whole        |
// |            message, its bytes are passed to the core under valid/ready,   |
// |            and the core digest is returned tagged with the requester id.  |
// | Ports    : clk, rst_n (async, active-low)                                  |
// |            req_valid/req_len/req_byte/req_byte_valid  per-requester in     |
// |            req_byte_ready, grant                      per-requester out    |
// |            rsp_valid/rsp_id/rsp_digest/rsp_err        response out         |
// |            core_m_valid/core_message/core_counter     to hash core         |
// |            core_byte_ready/core_hash_ready/core_digest from hash core      |
// | Options  : define HASH_ARB_TIMEOUT_EN to build the digest watchdog         |
// |            (TIMEOUT_CYCLES); without it WAIT holds until the core answers. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module hash_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*64-1:0] req_len,
  input  logic [NUM_REQ*8-1:0]  req_byte,
  input  logic [NUM_REQ-1:0]    req_byte_valid,
  output logic [NUM_REQ-1:0]    req_byte_ready,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_digest,
  output logic                  rsp_err,
  output logic                  core_m_valid,
  output logic [7:0]            core_message,
  output logic [63:0]           core_counter,
  input  logic                  core_byte_ready,
  input  logic                  core_hash_ready,
  input  logic [31:0]           core_digest
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]         state_q,     state_d;
  logic [ID_W-1:0]    rr_ptr_q,    rr_ptr_d;
  logic [ID_W-1:0]    gnt_idx_q,   gnt_idx_d;
  logic [NUM_REQ-1:0] grant_q,     grant_d;
  logic [63:0]        remaining_q, remaining_d;
  logic [63:0]        counter_q,   counter_d;
  logic [31:0]        digest_q,    digest_d;
  logic               err_q,       err_d;

  // Unpacked views of the flattened per-requester buses.
  logic [63:0] len_arr  [NUM_REQ];
  logic [7:0]  byte_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign len_arr[gi]  = req_len[64*gi +: 64];
    assign byte_arr[gi] = req_byte[8*gi +: 8];
  end

  // Round-robin search: first set req_valid bit at or above rr_ptr, wrapping.
  logic            pick_found;
  logic [ID_W-1:0] pick_idx;
  logic [ID_W-1:0] scan_idx;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!pick_found && req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  logic sel_byte_valid;
  logic xfer;

  assign sel_byte_valid = req_byte_valid[gnt_idx_q];
  assign xfer           = (state_q == S_STREAM) && sel_byte_valid && core_byte_ready;

  logic timeout_hit;

`ifdef HASH_ARB_TIMEOUT_EN
  // Counter is held at zero outside WAIT, so it restarts on every WAIT entry.
  logic [31:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = '0;
    if (state_q == S_WAIT) begin
      wait_cnt_d = wait_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Fires during the TIMEOUT_CYCLES-th WAIT cycle.
  assign timeout_hit = (state_q == S_WAIT) && (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      gnt_idx_q   <= '0;
      grant_q     <= '0;
      remaining_q <= '0;
      counter_q   <= '0;
      digest_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      grant_q     <= grant_d;
      remaining_q <= remaining_d;
      counter_q   <= counter_d;
      digest_q    <= digest_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_idx_d   = gnt_idx_q;
    grant_d     = grant_q;
    remaining_d = remaining_q;
    counter_d   = counter_q;
    digest_d    = digest_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d     = NUM_REQ'(1) << pick_idx;
          gnt_idx_d   = pick_idx;
          remaining_d = len_arr[pick_idx];
          counter_d   = len_arr[pick_idx];
          rr_ptr_d    = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
          digest_d    = '0;
          // A zero-length message never touches the core.
          if (len_arr[pick_idx] == 64'd0) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_STREAM;
          end
        end
      end

      S_STREAM: begin
        if (xfer) begin
          remaining_d = remaining_q - 64'd1;
          if (remaining_q == 64'd1) begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        // A digest arriving on the expiry cycle takes priority.
        if (core_hash_ready) begin
          digest_d = core_digest;
          err_d    = 1'b0;
          state_d  = S_RESP;
        end else if (timeout_hit) begin
          digest_d = '0;
          err_d    = 1'b1;
          state_d  = S_RESP;
        end
      end

      S_RESP: begin
        grant_d = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic.
  always_comb begin
    grant          = grant_q;
    core_counter   = counter_q;
    rsp_valid      = 1'b0;
    rsp_id         = '0;
    rsp_digest     = '0;
    rsp_err        = 1'b0;
    core_m_valid   = 1'b0;
    core_message   = '0;
    req_byte_ready = '0;

    case (state_q)
      S_STREAM: begin
        core_m_valid = sel_byte_valid;
        core_message = byte_arr[gnt_idx_q];
        if (core_byte_ready) begin
          req_byte_ready = NUM_REQ'(1) << gnt_idx_q;
        end
      end
      S_RESP: begin
        rsp_valid  = 1'b1;
        rsp_id     = gnt_idx_q;
        rsp_digest = digest_q;
        rsp_err    = err_q;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/hash_req_arbiter.md
# hash_req_arbiter

Shares one full-hash DES S-box core among `NUM_REQ` message sources.
- Selects a requester round-robin and locks the grant for the whole message.
- Streams that requester's bytes into the core with a valid/ready handshake, then waits for the core's digest.
- Returns the digest tagged with the requester index.
- Sits between the per-channel message sources and the single hash core instance.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, valid range 2–16.
- `ID_W`, default `$clog2(NUM_REQ)`: requester index width (derived).
- `TIMEOUT_CYCLES`, default 1024: digest watchdog limit, used only with `HASH_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NUM_REQ  per-requester message request, level
- `req_len`  in  NUM_REQ*64  per-requester message length in bytes; slice i = `[64*i+63:64*i]`
- `req_byte`  in  NUM_REQ*8  per-requester data byte; slice i = `[8*i+7:8*i]`
- `req_byte_valid`  in  NUM_REQ  byte valid
- `req_byte_ready`  out  NUM_REQ  byte accepted; only the granted bit can be 1
- `grant`  out  NUM_REQ  one-hot grant, registered
- `rsp_valid`  out  1  one-cycle response pulse, no backpressure
- `rsp_id`  out  ID_W  index of the completed requester
- `rsp_digest`  out  32  digest
- `rsp_err`  out  1  error flag (zero length or timeout)
- `core_m_valid`  out  1  byte valid to core
- `core_message`  out  8  byte to core
- `core_counter`  out  64  message length to core; constant for the whole message
- `core_byte_ready`  in  1  core can accept a byte this cycle
- `core_hash_ready`  in  1  core digest valid pulse
- `core_digest`  in  32  core digest

## Operation
- States: IDLE, STREAM, WAIT, RESP.
- **IDLE**
  - If any `req_valid` is set, pick the first set bit searching upward (with wrap) from `rr_ptr`.
  - Register `grant`, latch `req_len[i]` into `remaining` and `core_counter`, set `rr_ptr = i+1` (wrapping at `NUM_REQ`).
  - If the latched length is nonzero, go to STREAM.
  - If the latched length is zero, go to RESP with `rsp_err=1` and `rsp_digest=0`; the core is never touched.
- **STREAM** (combinational pass-through for granted requester i)
  - `core_m_valid = req_byte_valid[i]`, `core_message = req_byte[i]`, `req_byte_ready[i] = core_byte_ready`.
  - A transfer occurs when valid and ready are both 1; each transfer decrements `remaining`.
  - A transfer with `remaining==1` moves to WAIT.
- **WAIT**
  - `core_m_valid=0`.
  - On `core_hash_ready`, register `core_digest` and go to RESP.
- **RESP**
  - `rsp_valid=1` for exactly one cycle, with `rsp_id=i`.
  - Clear `grant`, go to IDLE.
- `core_hash_ready` outside WAIT is ignored.
- `req_valid` changes while a grant is held have no effect until IDLE.
- A requester must hold `req_valid` and `req_len` stable until its grant is seen, and must drop `req_valid` after `rsp_valid` to avoid re-arbitration.
- Lengths are full 64-bit unsigned. `remaining` never wraps; the zero case is handled in IDLE.

## Timing
- Reset values:
  - all outputs 0
  - state IDLE, `rr_ptr=0`, `remaining=0`, `core_counter=0`
  - takes effect immediately (asynchronous), including mid-message; `core_m_valid` drops the same instant.
  - The partially fed core is not cleaned up by this block; the core shares `rst_n`.
- Grant latency: `req_valid` sampled high at edge N gives `grant` high after edge N.
- First byte: can transfer in the cycle after edge N.
- Throughput: 1 byte/cycle while `core_byte_ready=1`.
- Response latency: `core_hash_ready` at edge M gives `rsp_valid` in the cycle after M, and `grant` clears after edge M+1.
- Minimum gap between messages: one IDLE cycle.
- Fairness: any continuously requesting source is granted within `NUM_REQ` messages.

## Configuration
- Macro: `HASH_ARB_TIMEOUT_EN`.
- Defined:
  - A counter runs in WAIT and clears on WAIT entry.
  - If it reaches `TIMEOUT_CYCLES` without `core_hash_ready`, go to RESP with `rsp_err=1` and `rsp_digest=0`.
  - A `core_hash_ready` on the same cycle as expiry wins: normal digest, `rsp_err=0`.
- Undefined: no counter is built; WAIT holds indefinitely, and `rsp_err` is set only for zero length.

## Test plan
- **Single request, 3 bytes.** Requester 0, `req_len=3`, bytes 0x41, 0x42, 0x43, core ready always, core returns 0xDEADBEEF 5 cycles later.
  - Expect `core_counter=3` for all 3 transfers, then `rsp_valid` for one cycle with `rsp_id=0` and `rsp_digest=0xDEADBEEF`.
- **Round-robin, 4 requesters.** All 4 hold requests with length 1.
  - Expect grants in order 0, 1, 2, 3.
  - Requesters 0 and 2 then re-request: expect grant order 0, 2.
- **Backpressure.** Requester 1, length 4, `core_byte_ready` toggled 1,0,0,1,1,0,1.
  - Expect exactly 4 transfers, `req_byte_ready[1]` mirroring core ready, other ready bits 0.
- **Zero length.** Requester 2 with `req_len=0`.
  - Expect `core_m_valid` never high, `rsp_valid` with `rsp_id=2`, `rsp_err=1`, digest 0.
- **Reset mid-stream.** `rst_n` low after 2 of 5 bytes.
  - Expect all outputs 0 immediately.
  - After release, requester 3 alone is granted first (`rr_ptr=0` search finds 3).
- **Timeout** (`HASH_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES=8`): core never responds.
  - Expect `rsp_err=1` in the cycle after the 8th WAIT cycle, then IDLE.
